// File: rtl/riscv_run_sequencer_pkg.sv
// Shared types and constants for the run sequencer.
//   seq_state_e       : sequencer FSM states
//   DefaultClrCycles  : default length of the instruction-memory clear pulse
//   DefaultFifoDepth  : default number of instruction-load FIFO entries
//   InstrAddrW/DataW  : instruction-memory write port widths
//   FifoWidth         : one FIFO entry, {addr, data}
package riscv_run_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StRun,
    StDone
  } seq_state_e;

  localparam int unsigned DefaultClrCycles = 4;
  localparam int unsigned DefaultFifoDepth = 4;

  localparam int unsigned InstrAddrW = 32;
  localparam int unsigned InstrDataW = 32;
  localparam int unsigned FifoWidth  = InstrAddrW + InstrDataW;

  // States in which the sequencer reports itself as busy.
  function automatic logic is_active(seq_state_e s);
    return (s == StClear) || (s == StLoad) || (s == StRun);
  endfunction

endpackage

// File: rtl/riscv_run_sequencer_instr_load_fifo.sv
// Instruction-load FIFO: holds {addr, data} words pushed by the host until the
// sequencer drains them into instruction memory.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset, empties the FIFO
//   flush_i  : synchronous flush; wins over a push or pop in the same cycle
//   push_i   : push request (ignored when full)
//   wdata_i  : entry to push
//   pop_i    : pop request (ignored when empty)
//   rdata_o  : head entry, valid while !empty_o
//   empty_o  : no entries stored
//   full_o   : Depth entries stored
module instr_load_fifo
  import riscv_run_sequencer_pkg::*;
#(
  parameter int unsigned Depth = DefaultFifoDepth,
  parameter int unsigned Width = FifoWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  // Count spans 0..Depth inclusive, so it needs Depth+1 states.
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/riscv_run_sequencer.sv
// Run sequencer for a RISC-V core: clears instruction memory, streams host
// instructions from a FIFO into it, then clock-enables the core for a fixed
// cycle budget and reports completion.
//   clk, reset_n              : clock, asynchronous active-low reset
//   i_start / i_abort         : one-cycle start (IDLE/DONE only) and abort pulses
//   i_clear                   : one-cycle acknowledge of DONE
//   i_num_cycle               : run budget, latched on an accepted start
//   i_load_end                : host has finished pushing instructions
//   i_wr_valid/addr/data      : FIFO push; o_wr_ready is its ready
//   o_mem_reset_n             : active-low instruction-memory clear
//   o_instr_write/addr/data   : instruction-memory write port
//   o_core_run                : core clock-enable
//   o_idle/o_running/o_done   : one-hot status
//   o_cycle_count             : cycles executed in the current/last run
module riscv_run_sequencer
  import riscv_run_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CYCLE_BIT = 32,
  parameter int unsigned FIFO_DEPTH    = DefaultFifoDepth,
  parameter int unsigned CLR_CYCLES    = DefaultClrCycles
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_clear,
  input  logic [NUM_CYCLE_BIT-1:0] i_num_cycle,
  input  logic                     i_load_end,
  input  logic                     i_wr_valid,
  input  logic [InstrAddrW-1:0]    i_wr_addr,
  input  logic [InstrDataW-1:0]    i_wr_data,
  output logic                     o_wr_ready,
  output logic                     o_mem_reset_n,
  output logic                     o_instr_write,
  output logic [InstrAddrW-1:0]    o_instr_addr,
  output logic [InstrDataW-1:0]    o_instr_data,
  output logic                     o_core_run,
  output logic                     o_idle,
  output logic                     o_running,
  output logic                     o_done,
  output logic [NUM_CYCLE_BIT-1:0] o_cycle_count
);

  localparam int unsigned ClrW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  seq_state_e state_q, state_d;

  logic [NUM_CYCLE_BIT-1:0] budget_q, budget_d;
  logic [NUM_CYCLE_BIT-1:0] count_q, count_d;
  logic [ClrW-1:0]          clr_cnt_q, clr_cnt_d;

  logic                  core_run_q, core_run_d;
  logic                  instr_write_q, instr_write_d;
  logic                  mem_reset_n_q, mem_reset_n_d;
  logic [InstrAddrW-1:0] instr_addr_q, instr_addr_d;
  logic [InstrDataW-1:0] instr_data_q, instr_data_d;
  logic                  idle_q, idle_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;

  logic                 fifo_push, fifo_pop, fifo_flush;
  logic                 fifo_empty, fifo_full;
  logic [FifoWidth-1:0] fifo_rdata;

  // Pushes are accepted in any state; the host sees backpressure only when full.
  assign fifo_push  = i_wr_valid && !fifo_full;
  assign o_wr_ready = !fifo_full;

  instr_load_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (FifoWidth)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i ({i_wr_addr, i_wr_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d       = state_q;
    budget_d      = budget_q;
    count_d       = count_q;
    clr_cnt_d     = clr_cnt_q;
    core_run_d    = 1'b0;
    instr_write_d = 1'b0;
    instr_addr_d  = instr_addr_q;
    instr_data_d  = instr_data_q;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Abort beats start even here, although there is nothing to tear down.
        if (i_start && !i_abort) begin
          budget_d  = i_num_cycle;
          count_d   = '0;
          clr_cnt_d = '0;
          state_d   = StClear;
        end
      end

      StClear: begin
        if (i_abort) begin
          fifo_flush = 1'b1;
          state_d    = StIdle;
        end else if (clr_cnt_q == ClrW'(CLR_CYCLES - 1)) begin
          state_d = StLoad;
        end else begin
          clr_cnt_d = clr_cnt_q + ClrW'(1);
        end
      end

      StLoad: begin
        if (i_abort) begin
          fifo_flush = 1'b1;
          state_d    = StIdle;
        end else if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          instr_write_d = 1'b1;
          instr_addr_d  = fifo_rdata[FifoWidth-1:InstrDataW];
          instr_data_d  = fifo_rdata[InstrDataW-1:0];
        end else if (i_load_end) begin
          // An empty FIFO means no pop this cycle, so no write is still in flight;
          // the last write is visible during this final LOAD cycle.
          if (budget_q == '0) begin
            state_d = StDone;
          end else begin
            state_d    = StRun;
            core_run_d = 1'b1;
          end
        end
      end

      StRun: begin
        if (i_abort) begin
          fifo_flush = 1'b1;
          state_d    = StIdle;
        end else begin
          // count_q < budget_q here, so the increment never wraps.
          count_d = count_q + NUM_CYCLE_BIT'(1);
          if (count_d == budget_q) begin
            state_d = StDone;
          end else begin
            core_run_d = 1'b1;
          end
        end
      end

      StDone: begin
        if (i_abort) begin
          fifo_flush = 1'b1;
          state_d    = StIdle;
        end else if (i_start) begin
          budget_d  = i_num_cycle;
          count_d   = '0;
          clr_cnt_d = '0;
          state_d   = StClear;
        end else if (i_clear) begin
          state_d = StIdle;
        end
      end

      default: begin
        fifo_flush = 1'b1;
        state_d    = StIdle;
      end
    endcase

    mem_reset_n_d = (state_d != StClear);
    idle_d        = (state_d == StIdle);
    running_d     = is_active(state_d);
    done_d        = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      budget_q      <= '0;
      count_q       <= '0;
      clr_cnt_q     <= '0;
      core_run_q    <= 1'b0;
      instr_write_q <= 1'b0;
      instr_addr_q  <= '0;
      instr_data_q  <= '0;
      mem_reset_n_q <= 1'b1;
      idle_q        <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      budget_q      <= budget_d;
      count_q       <= count_d;
      clr_cnt_q     <= clr_cnt_d;
      core_run_q    <= core_run_d;
      instr_write_q <= instr_write_d;
      instr_addr_q  <= instr_addr_d;
      instr_data_q  <= instr_data_d;
      mem_reset_n_q <= mem_reset_n_d;
      idle_q        <= idle_d;
      running_q     <= running_d;
      done_q        <= done_d;
    end
  end

  assign o_mem_reset_n = mem_reset_n_q;
  assign o_instr_write = instr_write_q;
  assign o_instr_addr  = instr_addr_q;
  assign o_instr_data  = instr_data_q;
  assign o_core_run    = core_run_q;
  assign o_idle        = idle_q;
  assign o_running     = running_q;
  assign o_done        = done_q;
  assign o_cycle_count = count_q;

endmodule

// File: tb/tb_riscv_run_sequencer.sv
module tb_riscv_run_sequencer;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CLR   = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_start = 1'b0, i_abort = 1'b0, i_clear = 1'b0;
  logic         i_load_end = 1'b0, i_wr_valid = 1'b0;
  logic [W-1:0] i_num_cycle = '0;
  logic [31:0]  i_wr_addr = '0, i_wr_data = '0;

  logic         o_wr_ready, o_mem_reset_n, o_instr_write, o_core_run;
  logic         o_idle, o_running, o_done;
  logic [31:0]  o_instr_addr, o_instr_data;
  logic [W-1:0] o_cycle_count;

  riscv_run_sequencer #(
    .NUM_CYCLE_BIT (W),
    .FIFO_DEPTH    (DEPTH),
    .CLR_CYCLES    (CLR)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_clear       (i_clear),
    .i_num_cycle   (i_num_cycle),
    .i_load_end    (i_load_end),
    .i_wr_valid    (i_wr_valid),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .o_wr_ready    (o_wr_ready),
    .o_mem_reset_n (o_mem_reset_n),
    .o_instr_write (o_instr_write),
    .o_instr_addr  (o_instr_addr),
    .o_instr_data  (o_instr_data),
    .o_core_run    (o_core_run),
    .o_idle        (o_idle),
    .o_running     (o_running),
    .o_done        (o_done),
    .o_cycle_count (o_cycle_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {MIdle, MClear, MLoad, MRun, MDone} mphase_e;
  mphase_e     m_phase;
  int          m_clr_left;
  int unsigned m_budget, m_count;
  logic [63:0] m_q[$];
  logic        m_wr;
  logic [63:0] m_wr_word;

  // Observations of the DUT, used by the hand-computed directed checks.
  int          obs_clr, obs_run;
  logic [63:0] obs_word[$];
  int          obs_cyc[$];

  task automatic model_reset();
    m_phase = MIdle;
    m_q.delete();
    m_count = 0;
    m_budget = 0;
    m_wr = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic ab, input logic cl, input int unsigned num,
                            input logic le, input logic wv, input logic [63:0] word);
    bit push;
    push = wv && (m_q.size() < DEPTH);
    m_wr = 1'b0;
    if (ab && m_phase != MIdle) begin
      m_phase = MIdle;
      m_q.delete();
    end else begin
      case (m_phase)
        MIdle, MDone: begin
          if (st && !ab) begin
            m_budget = num;
            m_count = 0;
            m_clr_left = CLR;
            m_phase = MClear;
          end else if (m_phase == MDone && cl) begin
            m_phase = MIdle;
          end
        end
        MClear: begin
          m_clr_left--;
          if (m_clr_left == 0) m_phase = MLoad;
        end
        MLoad: begin
          if (m_q.size() != 0) begin
            m_wr_word = m_q.pop_front();
            m_wr = 1'b1;
          end else if (le) begin
            m_phase = (m_budget == 0) ? MDone : MRun;
          end
        end
        MRun: begin
          m_count++;
          if (m_count == m_budget) m_phase = MDone;
        end
        default: m_phase = MIdle;
      endcase
      if (push) m_q.push_back(word);
    end
  endtask

  task automatic check_outputs();
    chk("idle", o_idle, m_phase == MIdle);
    chk("running", o_running, m_phase inside {MClear, MLoad, MRun});
    chk("done", o_done, m_phase == MDone);
    chk("core_run", o_core_run, m_phase == MRun);
    chk("mem_reset_n", o_mem_reset_n, m_phase != MClear);
    chk("wr_ready", o_wr_ready, m_q.size() < DEPTH);
    chk("instr_write", o_instr_write, m_wr);
    chk("cycle_count", o_cycle_count, m_count);
    if (m_wr) chk("instr_word", {o_instr_addr, o_instr_data}, m_wr_word);
  endtask

  initial begin : compare
    logic s_start, s_abort, s_clear, s_le, s_wv;
    logic [W-1:0] s_num;
    logic [63:0] s_word;
    model_reset();
    forever begin
      @(posedge clk);
      s_start = i_start;
      s_abort = i_abort;
      s_clear = i_clear;
      s_le    = i_load_end;
      s_wv    = i_wr_valid;
      s_num   = i_num_cycle;
      s_word  = {i_wr_addr, i_wr_data};
      #1;
      cyc++;
      if (!reset_n) model_reset();
      else model_step(s_start, s_abort, s_clear, int'(s_num), s_le, s_wv, s_word);
      check_outputs();
      if (!o_mem_reset_n) obs_clr++;
      if (o_core_run) obs_run++;
      if (o_instr_write) begin
        obs_word.push_back({o_instr_addr, o_instr_data});
        obs_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers (all start and end just after a negedge) ----------------
  task automatic clear_obs();
    obs_clr = 0;
    obs_run = 0;
    obs_word.delete();
    obs_cyc.delete();
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d, input int bound,
                           output bit ok);
    ok = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_addr  = a;
    i_wr_data  = d;
    for (int k = 0; k < bound && !ok; k++) begin
      if (o_wr_ready) ok = 1'b1;
      @(negedge clk);
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [W-1:0] n);
    i_start = 1'b1;
    i_num_cycle = n;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!o_done && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done", o_done, 1'b1);
  endtask

  task automatic wait_run(input int bound);
    int k = 0;
    while (!o_core_run && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_run", o_core_run, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_idle"}, o_idle, 1'b1);
    chk({tag, "_running"}, o_running, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_core_run"}, o_core_run, 1'b0);
    chk({tag, "_instr_write"}, o_instr_write, 1'b0);
    chk({tag, "_mem_reset_n"}, o_mem_reset_n, 1'b1);
    chk({tag, "_wr_ready"}, o_wr_ready, 1'b1);
    chk({tag, "_count"}, o_cycle_count, 0);
    chk({tag, "_addr_data"}, {o_instr_addr, o_instr_data}, 64'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Three words, budget 5.
    i_load_end = 1'b1;
    for (int k = 0; k < 3; k++) push_word(32'(4 * k), 32'hC0DE_0000 + 32'(k), 4, ok);
    clear_obs();
    pulse_start(W'(5));
    wait_done(60);
    chk("t1_clr_cycles", obs_clr, 4);
    chk("t1_writes", obs_word.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < obs_word.size()) chk("t1_word", obs_word[k], {32'(4 * k), 32'hC0DE_0000 + 32'(k)});
    chk("t1_run_cycles", obs_run, 5);
    chk("t1_count", o_cycle_count, 5);
    pulse_clear();
    chk("t1_idle", o_idle, 1'b1);

    // Zero budget, empty FIFO.
    clear_obs();
    pulse_start(W'(0));
    wait_done(30);
    chk("t2_clr_cycles", obs_clr, 4);
    chk("t2_run_cycles", obs_run, 0);
    chk("t2_writes", obs_word.size(), 0);
    chk("t2_count", o_cycle_count, 0);
    pulse_clear();

    // Fill to depth, fifth push blocked, then stream through LOAD.
    i_load_end = 1'b0;
    for (int k = 0; k < 4; k++) push_word(32'h100 + 32'(4 * k), 32'(k), 4, ok);
    chk("t3_ready_full", o_wr_ready, 1'b0);
    push_word(32'h110, 32'(4), 3, ok);
    chk("t3_fifth_blocked", ok, 1'b0);
    clear_obs();
    pulse_start(W'(2));
    for (int k = 4; k < 10; k++) begin
      push_word(32'h100 + 32'(4 * k), 32'(k), 20, ok);
      chk("t3_push_ok", ok, 1'b1);
    end
    i_load_end = 1'b1;
    wait_done(40);
    chk("t3_writes", obs_word.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < obs_word.size()) chk("t3_word", obs_word[k], {32'h100 + 32'(4 * k), 32'(k)});
    if (obs_cyc.size() == 10) chk("t3_back_to_back", obs_cyc[9] - obs_cyc[0], 9);
    pulse_clear();

    // Abort in RUN after two run cycles, with a word pushed meanwhile.
    clear_obs();
    pulse_start(W'(10));
    wait_run(20);
    push_word(32'hDEAD_0000, 32'hBEEF, 2, ok);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("t4_core_run", o_core_run, 1'b0);
    chk("t4_idle", o_idle, 1'b1);
    chk("t4_ready", o_wr_ready, 1'b1);
    chk("t4_run_cycles", obs_run, 2);
    clear_obs();
    pulse_start(W'(1));
    wait_done(30);
    chk("t4_flushed", obs_word.size(), 0);
    chk("t4_rerun", obs_run, 1);
    pulse_clear();

    // Start in RUN ignored; start in DONE restarts.
    clear_obs();
    pulse_start(W'(4));
    wait_run(20);
    pulse_start(W'(7));
    wait_done(30);
    chk("t5_run_cycles", obs_run, 4);
    chk("t5_count", o_cycle_count, 4);
    clear_obs();
    pulse_start(W'(3));
    wait_done(30);
    chk("t5_restart_clr", obs_clr, 4);
    chk("t5_restart_run", obs_run, 3);
    chk("t5_restart_count", o_cycle_count, 3);
    pulse_clear();

    // Maximum budget runs to completion.
    clear_obs();
    pulse_start(W'(15));
    wait_done(60);
    chk("t6_count", o_cycle_count, 15);
    chk("t6_run_cycles", obs_run, 15);
    pulse_clear();

    // Reset mid-LOAD.
    i_load_end = 1'b0;
    for (int k = 0; k < 3; k++) push_word(32'h200 + 32'(4 * k), 32'(k), 4, ok);
    clear_obs();
    pulse_start(W'(5));
    n = 0;
    while (obs_word.size() == 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t7_first_write", obs_word.size() > 0, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("t7");
    n = obs_word.size();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t7_no_more_writes", obs_word.size(), n);
    chk("t7_idle", o_idle, 1'b1);
    chk("t7_fifo_empty", o_wr_ready, 1'b1);

    // Randomised traffic.
    for (int it = 0; it < 4000; it++) begin
      i_start    = ($urandom_range(0, 11) == 0);
      i_abort    = ($urandom_range(0, 59) == 0);
      i_clear    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) i_load_end = ~i_load_end;
      i_num_cycle = ($urandom_range(0, 7) == 0) ? W'(15) : W'($urandom_range(0, 6));
      i_wr_valid = 1'($urandom_range(0, 1));
      i_wr_addr  = $urandom;
      i_wr_data  = $urandom;
      @(negedge clk);
    end
    i_start = 1'b0;
    i_abort = 1'b0;
    i_clear = 1'b0;
    i_wr_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_run_sequencer.md
RISCV_RUN_SEQUENCER -- requirements
Module: riscv_run_sequencer

Interface
REQ-001 SHALL have parameter NUM_CYCLE_BIT, default 32, meaning the width of the cycle budget and the cycle counter.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two), meaning the number of entries in the instruction-load FIFO.
REQ-003 SHALL have parameter CLR_CYCLES, default 4, meaning the number of cycles o_mem_reset_n is held low.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have i_start (input, 1) as a one-cycle start pulse, and i_abort (input, 1) as a one-cycle abort pulse.
REQ-007 SHALL have i_clear (input, 1) as a one-cycle pulse that acknowledges DONE.
REQ-008 SHALL have i_num_cycle (input, NUM_CYCLE_BIT) as the run budget, sampled on an accepted i_start.
REQ-009 SHALL have i_load_end (input, 1) as a level signal meaning the host has finished pushing instructions.
REQ-010 SHALL have i_wr_valid (input, 1), i_wr_addr (input, 32) and i_wr_data (input, 32) as the FIFO push request, with o_wr_ready (output, 1) as its ready.
REQ-011 SHALL have o_mem_reset_n (output, 1) as the active-low instruction-memory clear.
REQ-012 SHALL have o_instr_write (output, 1), o_instr_addr (output, 32) and o_instr_data (output, 32) as the instruction-memory write port.
REQ-013 SHALL have o_core_run (output, 1) as the core clock-enable.
REQ-014 SHALL have o_idle, o_running and o_done (outputs, 1 each) as one-hot status, and o_cycle_count (output, NUM_CYCLE_BIT) as the cycles executed.

Function
REQ-015 SHALL implement the states IDLE, CLEAR, LOAD, RUN and DONE; all outputs SHALL be registered.
REQ-016 IDLE: i_start SHALL latch i_num_cycle, zero o_cycle_count and go to CLEAR; i_start SHALL be ignored in every state except IDLE and DONE.
REQ-017 CLEAR: o_mem_reset_n SHALL be 0 for exactly CLR_CYCLES cycles, then the FSM SHALL go to LOAD.
REQ-018 LOAD: while the FIFO is non-empty, the FSM SHALL pop one entry per cycle; o_instr_write SHALL be 1 for one cycle, with that entry's addr and data, in the cycle after the pop.
REQ-019 LOAD exit: when the FIFO is empty, i_load_end=1 and no write is pending, the FSM SHALL go to RUN, or straight to DONE if the latched budget is 0.
REQ-020 RUN: o_core_run SHALL be 1 for exactly the budget N cycles, and o_cycle_count SHALL increment on each of those cycles, ending at N.
REQ-021 RUN: after the Nth cycle, the FSM SHALL go to DONE with o_core_run=0 in the same edge.
REQ-022 DONE: o_done SHALL hold until i_clear (go to IDLE) or i_start (go to CLEAR with a new budget); o_cycle_count SHALL hold its value.
REQ-023 o_running SHALL be 1 in CLEAR, LOAD and RUN; o_idle SHALL be 1 only in IDLE.
REQ-024 FIFO: o_wr_ready SHALL equal !full from the current count; pushes SHALL be accepted in any state, and pops SHALL occur only in LOAD.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged; a push when full SHALL not occur because ready is 0.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be FIFO_DEPTH+1 states wide.
REQ-027 i_abort in CLEAR, LOAD, RUN or DONE SHALL, on the next edge, give IDLE, flush the FIFO, and force o_core_run=0, o_instr_write=0 and o_mem_reset_n=1.
REQ-028 If i_abort and i_start occur in the same cycle, i_abort SHALL win.
REQ-029 The cycle counter SHALL not wrap: a budget of 2^NUM_CYCLE_BIT-1 SHALL run to completion.

Reset
REQ-030 On reset_n=0, the FSM SHALL go to IDLE and the FIFO SHALL be emptied.
REQ-031 Reset values SHALL be o_idle=1, o_running=0, o_done=0, o_core_run=0, o_instr_write=0, o_mem_reset_n=1, o_wr_ready=1, and o_cycle_count, o_instr_addr and o_instr_data all 0.
REQ-032 Reset asserted mid-RUN or mid-LOAD SHALL abandon the operation without emitting a further write or run cycle.

Structure
REQ-033 A shared package SHALL hold the state encoding and the constants for default CLR_CYCLES and FIFO_DEPTH.
REQ-034 The FIFO SHALL be a separate sub-module, instr_load_fifo, 64 bits wide with {addr,data} entries; the FSM and counter SHALL be in the top level.

Verification
REQ-035 Push 3 words (addr 0/4/8), set i_load_end=1, start with N=5 -> 4 cycles of mem_reset_n=0, then 3 write pulses in order, then core_run high for exactly 5 cycles, then o_done=1 and o_cycle_count=5.
REQ-036 Start with N=0 and an empty FIFO with load_end=1 -> CLEAR then DONE, core_run never high, o_cycle_count=0.
REQ-037 Push 5 words at depth 4 without a start -> wr_ready falls after 4 pushes; in LOAD, pushing and popping concurrently keeps throughput at 1 per cycle.
REQ-038 Abort in RUN at cycle 2 of N=10 -> core_run=0 next cycle, o_idle=1, FIFO empty.
REQ-039 Start in RUN is ignored; start in DONE with N=3 -> a fresh CLEAR/LOAD/RUN of 3 cycles.
REQ-040 Assert reset_n=0 mid-LOAD -> all outputs at reset values asynchronously, with no further o_instr_write.
